stochastic_bitstream_gen: RTL

STOCHASTIC_BITSTREAM_GEN -- requirements
Module: stochastic_bitstream_gen

---
 rtl/stochastic_bitstream_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/stochastic_bitstream_gen.sv
// Stochastic bitstream generator: turns an unsigned probability word into a
// stream of len_in bits, each bit being 1 when the incoming random word is
// below the latched probability. Bits leave through a valid/ready handshake
// and the number of ones in the stream is reported alongside a done pulse.
module stochastic_bitstream_gen #(
  parameter int WIDTH = 20,
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] val_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic [LEN_W-1:0] ones_count,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   ones_q, ones_d;
  logic               bit_q, bit_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               genBit;
  logic               genCond;
  logic               transfer;

  assign genBit    = (r < val_q);
  assign transfer  = valid_q & bit_ready;
  assign genCond   = (remaining_q != '0) & (~valid_q | bit_ready);

  assign req_ready  = (state_q == IDLE);
  assign bit_out    = bit_q;
  assign bit_valid  = valid_q;
  assign ones_count = ones_q;
  assign done       = done_q;

  // Next-state logic: accept in IDLE, emit/hold bits in RUN, one-cycle DONE.
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    remaining_d = remaining_q;
    ones_d      = ones_q;
    bit_d       = bit_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          val_d       = val_in;
          remaining_d = len_in;
          ones_d      = '0;
          valid_d     = 1'b0;
          if (len_in != '0) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (genCond) begin
          bit_d       = genBit;
          valid_d     = 1'b1;
          remaining_d = remaining_q - LEN_ONE;
          ones_d      = ones_q + LEN_W'(genBit);
        end else if ((remaining_q == '0) && transfer) begin
          valid_d = 1'b0;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any stream in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      val_q       <= '0;
      remaining_q <= '0;
      ones_q      <= '0;
      bit_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      remaining_q <= remaining_d;
      ones_q      <= ones_d;
      bit_q       <= bit_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

endmodule
